// File: rtl/irq_source_regs_pkg.sv
// irq_source_regs_pkg: register offsets, field sizes and bus helpers shared by
// the IRQ source block, the interrupt controller and drivers.
package irq_source_regs_pkg;

    localparam logic [3:0] REG_PEND = 4'h0;
    localparam logic [3:0] REG_EN   = 4'h1;
    localparam logic [3:0] REG_MODE = 4'h2;
    localparam logic [3:0] REG_LVL0 = 4'h4;
    localparam int LVL_W      = 3;
    localparam int NUM_LEVELS = 7;

    typedef enum logic {ST_IDLE, ST_ACK} bus_state_e;

    function automatic logic [31:0] wb_merge(input logic [31:0] old, input logic [31:0] wdat,
                                             input logic [3:0] sel);
        logic [31:0] m;
        m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old & ~m) | (wdat & m);
    endfunction

endpackage

// File: rtl/irq_source_regs_if.sv
// irq_source_regs_if: classic Wishbone single-cycle slave port of the IRQ source block.
interface irq_source_regs_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                    input  wb_dat_o, wb_ack_o);
    modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                    output wb_dat_o, wb_ack_o);

endinterface

// File: rtl/irq_source_regs_sync.sv
// irq_sync: per-bit STAGES-deep synchroniser, one extra delay stage and a
// registered rising-edge pulse, so edge and level paths share the same latency.
module irq_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         wb_clk_i,
    input  logic         wb_reset_n_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] s_d,
    output logic [W-1:0] rise
);

    logic [STAGES-1:0][W-1:0] chain;

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            chain <= '0;
            s_d   <= '0;
            rise  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            s_d   <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~s_d;
        end
    end

endmodule

// File: rtl/irq_source_regs.sv
// irq_source_regs: Wishbone register file collecting N_SRC IRQ lines into
// seven registered level requests for the interrupt controller.
module irq_source_regs
    import irq_source_regs_pkg::*;
#(
    parameter int N_SRC       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_reset_n_i,
    irq_source_regs_if.slave      wb,
    input  logic [N_SRC-1:0]      irq_i,
    output logic [NUM_LEVELS-1:0] int_o
);

    bus_state_e                   state_q, state_d;
    logic                         req, wr;
    logic [N_SRC-1:0]             pend_q, en_q, mode_q, pend_d, clr, s_d, rise;
    logic [N_SRC-1:0][LVL_W-1:0]  lvl_q;
    logic [127:0]                 lvl_flat;
    logic [6:0]                   lvl_base;
    logic [31:0]                  rdata;
    logic [NUM_LEVELS-1:0]        int_d;

    irq_sync #(.W(N_SRC), .STAGES(SYNC_STAGES)) u_sync (
        .wb_clk_i     (wb_clk_i),
        .wb_reset_n_i (wb_reset_n_i),
        .d            (irq_i),
        .s_d          (s_d),
        .rise         (rise)
    );

    // ack is high for exactly the one cycle spent in ST_ACK
    always_comb begin
        req     = wb.wb_cyc_i && wb.wb_stb_i && state_q == ST_IDLE;
        wr      = req && wb.wb_we_i;
        state_d = req ? ST_ACK : ST_IDLE;
    end

    assign wb.wb_ack_o = state_q == ST_ACK;

    always_comb begin
        lvl_flat = '0;
        for (int n = 0; n < N_SRC; n++) lvl_flat[4 * n +: LVL_W] = lvl_q[n];
    end

    always_comb begin
        lvl_base = {wb.wb_adr_i[1:0], 5'b0};
        clr      = (wr && wb.wb_adr_i == REG_PEND) ? N_SRC'(wb_merge('0, wb.wb_dat_i, wb.wb_sel_i)) : '0;
        // a new edge wins over a same-cycle W1C so no edge is lost
        pend_d   = (mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & s_d);
        rdata    = wb.wb_adr_i == REG_PEND ? 32'(pend_q) :
                   wb.wb_adr_i == REG_EN   ? 32'(en_q) :
                   wb.wb_adr_i == REG_MODE ? 32'(mode_q) :
                   wb.wb_adr_i[3:2] == REG_LVL0[3:2] ? lvl_flat[lvl_base +: 32] : '0;
    end

    always_comb begin
        int_d = '0;
        for (int k = 0; k < NUM_LEVELS; k++)
            for (int n = 0; n < N_SRC; n++)
                int_d[k] = int_d[k] | (pend_q[n] & en_q[n] & (lvl_q[n] == LVL_W'(k + 1)));
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q     <= ST_IDLE;
            wb.wb_dat_o <= '0;
            pend_q      <= '0;
            en_q        <= '0;
            mode_q      <= '0;
            lvl_q       <= '0;
            int_o       <= '0;
        end else begin
            state_q     <= state_d;
            wb.wb_dat_o <= req ? rdata : '0;
            pend_q      <= pend_d;
            int_o       <= int_d;
            if (wr && wb.wb_adr_i == REG_EN)
                en_q <= N_SRC'(wb_merge(32'(en_q), wb.wb_dat_i, wb.wb_sel_i));
            if (wr && wb.wb_adr_i == REG_MODE)
                mode_q <= N_SRC'(wb_merge(32'(mode_q), wb.wb_dat_i, wb.wb_sel_i));
            for (int n = 0; n < N_SRC; n++)
                if (wr && wb.wb_adr_i[3:2] == REG_LVL0[3:2] && wb.wb_adr_i[1:0] == 2'(n / 8)
                    && wb.wb_sel_i[(n % 8) / 2])
                    lvl_q[n] <= wb.wb_dat_i[4 * (n % 8) +: LVL_W];
        end
    end

endmodule
